// File: rtl/ctrl_pkg.sv
// Shared controller-section definitions: scheduler state encoding and the
// smallest divisor that still leaves a gap between consecutive ticks.
`default_nettype none

package ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

    localparam int MIN_DIV = 2;

endpackage

`default_nettype wire

// File: rtl/tick_cnt.sv
// Loadable period counter: counts 0..div-1 while enabled and wraps to 0;
// clear has priority over counting.
`default_nettype none

module tick_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // ">=" rather than "==" keeps the counter bounded even if div is ever
    // smaller than the current count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q >= div - CNT_W'(1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/tick_sched.sv
// Programmable tick scheduler: emits single-cycle ticks every div_q cycles,
// either as a counted burst or continuously until stopped.
`default_nettype none

module tick_sched
    import ctrl_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               tick,
    output logic               done,
    output logic               cfg_err
);

    sched_state_e       state_q, state_d;
    logic [CNT_W-1:0]   div_q,   div_d;
    logic [BURST_W-1:0] rem_q,   rem_d;
    logic               done_q,  done_d;
    logic               err_q,   err_d;
    logic               cnt_zero;

    // Counter is held at zero throughout IDLE, so the first RUN cycle ticks.
    tick_cnt #(
        .CNT_W (CNT_W)
    ) u_tick_cnt (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clear  (state_q == IDLE),
        .en     (state_q == RUN),
        .div    (div_q),
        .zero   (cnt_zero)
    );

    assign tick = (state_q == RUN) && cnt_zero;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_div >= CNT_W'(MIN_DIV)) begin
                        state_d = RUN;
                        div_d   = cfg_div;
                        rem_d   = cfg_burst;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // rem_q == 0 means continuous mode: never decremented.
                if (tick && (rem_q != '0)) begin
                    rem_d = rem_q - BURST_W'(1);
                end
                if (stop || (tick && (rem_q == BURST_W'(1)))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign cfg_err = err_q;

endmodule

`default_nettype wire

// File: doc/tick_sched.md
# tick_sched

Programmable tick scheduler for the controller section of the verification platform. It generates single-cycle `tick` enables at a runtime-loaded divisor. Ticks come either as a counted burst or continuously until stopped, under a start/stop/busy/done handshake. Downstream blocks use it to pace stimulus and sampling.

## Interface
- `CNT_W`, 16, width of divisor and internal period counter; max divisor 2^CNT_W−1
- `BURST_W`, 8, width of burst length; 0 means continuous
- `clk_in`  input  1  clock, all logic on rising edge
- `rst_n`  input  1  reset, asynchronous, active-low
- `cfg_div`  input  CNT_W  tick period in cycles; legal range ≥2
- `cfg_burst`  input  BURST_W  number of ticks per run; 0 = run until `stop`
- `start`  input  1  single-cycle request; sampled only in IDLE
- `stop`  input  1  single-cycle abort; sampled only in RUN
- `busy`  output  1  high while in RUN
- `tick`  output  1  one-cycle enable pulse
- `done`  output  1  registered one-cycle pulse on run completion or stop
- `cfg_err`  output  1  registered one-cycle pulse when `start` is rejected

## Operation
- States: IDLE, RUN.
- IDLE, `start`=1, `cfg_div`≥2: latch `cfg_div` into `div_q`, latch `cfg_burst` into `rem_q`, clear period counter, go to RUN.
- IDLE, `start`=1, `cfg_div`<2: `cfg_err`=1 next cycle, stay IDLE, latch nothing.
- `stop` in IDLE is ignored. `start` in RUN is ignored.
- `cfg_*` changes during RUN are ignored; latched copies are used until the run ends.
- RUN: period counter counts 0..`div_q`−1 and wraps to 0.
- `tick` = (state==RUN) && (counter==0). This is combinational from registers, with no input path.
- On each tick with `rem_q`≠0: decrement `rem_q`. If `rem_q`==1 at that tick, this is the last tick: next state IDLE, `done`=1 next cycle.
- `rem_q`==0 latched: continuous mode; no decrement, no auto-termination.
- RUN with `stop`=1: next state IDLE, `done`=1 next cycle. A tick coinciding with the `stop` cycle is still emitted. No tick after that.
- Last tick and `stop` in the same cycle: a single `done` pulse.
- Back-to-back: `start` in the cycle where `done`=1 (state already IDLE) is accepted.
- Reset, including mid-run: state IDLE, counter 0, `div_q` 0, `rem_q` 0. `busy`/`tick`/`done`/`cfg_err` = 0 immediately (asynchronous). No `done` is generated by reset.

## Timing
- `start` accepted at edge t. Then `busy`=1 from cycle t+1, and the first `tick` is in cycle t+1.
- Tick k (k=0..N−1) occurs in cycle t+1+k·D, where D=`div_q`.
- Burst N≥1: `done` in cycle t+2+(N−1)·D. `busy` drops in that same cycle.
- `stop` sampled at edge s: `busy`=0 and `done`=1 in cycle s+1.
- `cfg_err` appears one cycle after the rejected `start`.
- `done` and `cfg_err` are never high together. `tick` and `done` are never high together.

## Structure
- Shared package `ctrl_pkg`: state enum (IDLE, RUN) and constant `MIN_DIV`=2.
- Sub-module `tick_cnt`: loadable period counter with `clear` and `en` inputs, a `div` input and a `zero` output, plus wrap at `div`−1.
- The top level holds the FSM, the config latches, the burst down-counter and the output registers.

## Test plan
- Reset check: assert `rst_n`=0 with random inputs → `busy`=`tick`=`done`=`cfg_err`=0. After release with no `start`, the block stays IDLE for 50 cycles with no `tick`.
- `cfg_div`=4, `cfg_burst`=3, `start` at edge 0 → `tick` in cycles 1, 5, 9; `done` in cycle 10; `busy`=1 in cycles 1..9 only.
- `cfg_div`=2, `cfg_burst`=0, `start` at edge 0, `stop` in cycle 7 → ticks in 1, 3, 5, 7; `done` in 8; no tick afterward.
- `cfg_div`=1 `start` → `cfg_err` in cycle 1, `busy` stays 0. Then `cfg_div`=0 → same result.
- Run with `cfg_div`=3, `cfg_burst`=2; change `cfg_div` to 7 and pulse `start` during RUN → ticks at 1 and 4, `done` at 5. A `start` in cycle 5 with `cfg_div`=5, `cfg_burst`=1 → tick at 6, `done` at 7.
- `cfg_div`=8, `cfg_burst`=10; drop `rst_n` in cycle 20 → all outputs 0 immediately. After release, no `done` and no `tick` until the next `start`.
